// File: rtl/fsm_pkg.sv
// Shared constants for the parametrised multicycle controller.
// Holds opcode codes, the 4-bit state encodings, address-mux selects,
// the packed control-word type and a wait-state helper.
package fsm_pkg;

   // Opcodes; any code at or above OP_LIMIT is illegal.
   localparam logic [2:0] OP_SUM = 3'd0;
   localparam logic [2:0] OP_RES = 3'd1;
   localparam logic [2:0] OP_MOV = 3'd2;
   localparam logic [2:0] OP_OUT = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_JMP = 3'd6;
   localparam logic [2:0] OP_HLT = 3'd7;
   localparam int unsigned OP_LIMIT = 8;

   // State encodings (also exported on estado for debug).
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_F    = 4'd1;
   localparam logic [3:0] ST_D    = 4'd2;
   localparam logic [3:0] ST_OP1  = 4'd3;
   localparam logic [3:0] ST_OP2  = 4'd4;
   localparam logic [3:0] ST_WC   = 4'd5;
   localparam logic [3:0] ST_GA   = 4'd6;
   localparam logic [3:0] ST_WB   = 4'd7;
   localparam logic [3:0] ST_OA   = 4'd8;
   localparam logic [3:0] ST_JP   = 4'd9;
   localparam logic [3:0] ST_COU  = 4'd10;
   localparam logic [3:0] ST_HALT = 4'd11;
   localparam logic [3:0] ST_ERR  = 4'd12;

   // Address mux selects.
   localparam logic [2:0] SEL_PC  = 3'd0;
   localparam logic [2:0] SEL_OP1 = 3'd1;
   localparam logic [2:0] SEL_OP2 = 3'd2;
   localparam logic [2:0] SEL_DST = 3'd3;
   localparam logic [2:0] SEL_JMP = 3'd4;

   // Moore control word decoded from the state register.
   typedef struct packed {
      logic       enmem;
      logic       wrmem;
      logic       enir;
      logic       enrop1;
      logic       enrop2;
      logic       enrio;
      logic       enpc;
      logic       halted;
      logic       error;
      logic [2:0] selmux;
   } ctrl_t;

   // States that wait on mem_ready and are guarded by the watchdog.
   function automatic logic is_wait_state(input logic [3:0] st);
      return (st == ST_F) || (st == ST_WC) || (st == ST_WB);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating wait-state counter with a programmable limit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear the count (has priority over inc)
//   inc        : count one more wait cycle
//   limit      : count value at which expired asserts
//   expired    : count has reached limit
module wait_timer #(
   parameter int unsigned TIMEOUT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 inc,
   input  logic [TIMEOUT_W-1:0] limit,
   output logic                 expired
);

   logic [TIMEOUT_W-1:0] cnt_q;
   logic [TIMEOUT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {TIMEOUT_W{1'b1}})) begin
         // Saturate rather than wrap so a stuck memory can never look fresh.
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == limit);

endmodule

// File: rtl/fsm_control_param.sv
// Parametrised multicycle control unit for the accumulator/memory CPU.
// Sequences fetch, decode, operand fetch, write-back, I/O, jump and halt,
// with a mem_ready handshake guarded by a wait-state watchdog.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : run enable, sampled in IDLE, JP and COU
//   operacion           : opcode from IR
//   mem_ready           : memory access complete
//   enmem, wrmem        : memory enable / write
//   enir, enrop1/2      : IR and operand register loads
//   enrio, enpc         : output register load, PC update
//   seloper, selmux     : ALU op select, address mux select
//   halted, error       : sticky status (absorbing states)
//   estado              : current state for debug
module fsm_control_param
   import fsm_pkg::*;
#(
   parameter int unsigned OP_W      = 3,
   parameter int unsigned TIMEOUT_W = 4,
   parameter int unsigned MAX_WAIT  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [OP_W-1:0] operacion,
   input  logic            mem_ready,
   output logic            enmem,
   output logic            wrmem,
   output logic            enir,
   output logic            enrop1,
   output logic            enrop2,
   output logic            enrio,
   output logic            enpc,
   output logic [OP_W-1:0] seloper,
   output logic [2:0]      selmux,
   output logic            halted,
   output logic            error,
   output logic [3:0]      estado
);

   // A limit of 0 turns the watchdog off.
   localparam bit                   WD_EN      = (MAX_WAIT != 0);
   localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(MAX_WAIT);

   logic [3:0]  state_q;
   logic [3:0]  state_d;
   logic [31:0] op_ext;
   logic        in_wait;
   logic        expired;
   logic        timeout;
   ctrl_t       ctrl;

   assign op_ext  = 32'(operacion);
   assign in_wait = is_wait_state(state_q);
   // mem_ready has priority: timeout only fires on a cycle without ready.
   assign timeout = WD_EN && in_wait && !mem_ready && expired;

   wait_timer #(
      .TIMEOUT_W(TIMEOUT_W)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_d != state_q),
      .inc    (in_wait && !mem_ready),
      .limit  (WAIT_LIMIT),
      .expired(expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_F;
         ST_F: begin
            if (mem_ready)    state_d = ST_D;
            else if (timeout) state_d = ST_ERR;
         end
         ST_D: begin
            if (op_ext >= OP_LIMIT) begin
               state_d = ST_ERR;
            end else begin
               case (op_ext[2:0])
                  OP_SUM, OP_RES, OP_AND, OP_OR: state_d = ST_OP1;
                  OP_MOV:                        state_d = ST_GA;
                  OP_OUT:                        state_d = ST_OA;
                  OP_JMP:                        state_d = ST_JP;
                  OP_HLT:                        state_d = ST_HALT;
                  default:                       state_d = ST_ERR;
               endcase
            end
         end
         ST_OP1: state_d = ST_OP2;
         ST_OP2: state_d = ST_WC;
         ST_GA:  state_d = ST_WB;
         ST_WC, ST_WB: begin
            if (mem_ready)    state_d = ST_COU;
            else if (timeout) state_d = ST_ERR;
         end
         ST_OA:         state_d = ST_COU;
         ST_JP, ST_COU: state_d = start ? ST_F : ST_IDLE;
         ST_HALT:       state_d = ST_HALT;
         ST_ERR:        state_d = ST_ERR;
         default:       state_d = ST_ERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore decode; seloper passes operacion through only where the ALU uses it.
   always_comb begin
      ctrl    = '0;
      seloper = '0;
      case (state_q)
         ST_F: begin
            ctrl.enmem  = 1'b1;
            ctrl.enir   = 1'b1;
            ctrl.selmux = SEL_PC;
         end
         ST_OP1, ST_GA: begin
            ctrl.enrop1 = 1'b1;
            ctrl.selmux = SEL_OP1;
         end
         ST_OP2: begin
            ctrl.enrop2 = 1'b1;
            ctrl.selmux = SEL_OP2;
            seloper     = operacion;
         end
         ST_WC: begin
            ctrl.enmem  = 1'b1;
            ctrl.wrmem  = 1'b1;
            ctrl.selmux = SEL_DST;
         end
         ST_WB: begin
            ctrl.enmem  = 1'b1;
            ctrl.wrmem  = 1'b1;
            ctrl.selmux = SEL_OP2;
            seloper     = operacion;
         end
         ST_OA: begin
            ctrl.enrio  = 1'b1;
            ctrl.selmux = SEL_OP1;
         end
         ST_JP: begin
            ctrl.enpc   = 1'b1;
            ctrl.selmux = SEL_JMP;
         end
         ST_COU:  ctrl.enpc   = 1'b1;
         ST_HALT: ctrl.halted = 1'b1;
         ST_ERR:  ctrl.error  = 1'b1;
         default: ;
      endcase
   end

   assign enmem  = ctrl.enmem;
   assign wrmem  = ctrl.wrmem;
   assign enir   = ctrl.enir;
   assign enrop1 = ctrl.enrop1;
   assign enrop2 = ctrl.enrop2;
   assign enrio  = ctrl.enrio;
   assign enpc   = ctrl.enpc;
   assign selmux = ctrl.selmux;
   assign halted = ctrl.halted;
   assign error  = ctrl.error;
   assign estado = state_q;

endmodule
